mvu_weight_loader: RTL and testbench

//  Upstream feeder for the MVU weight memories: packs a narrow host word stream into full weight-bank words.

---
 rtl/mvu_pkg.sv | 22 ++
 rtl/mvu_beat_packer.sv | 50 +++++
 rtl/mvu_weight_loader.sv | 187 ++++++++++++++++++
 tb/tb_mvu_weight_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// MVU array geometry shared by the weight loader and its packer.
// Also holds the loader state encoding and a small width helper.
package mvu_pkg;

  localparam int NMVU    = 8;
  localparam int BWBANKA = 9;
  localparam int BWBANKW = 4096;
  localparam int BWLBIN  = 32;

  typedef enum logic [1:0] {
    WL_IDLE,
    WL_FILL,
    WL_WRITE,
    WL_FIN
  } wl_state_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvu_beat_packer.sv
// Serial-to-parallel packer: beat k of a word lands in bits [k*BIN +: BIN], first beat in the LSBs.
// word_nxt is the packed word including the beat on din, so the final beat can be consumed in its own cycle.
module mvu_beat_packer #(
  parameter int BIN = 32,
  parameter int BWW = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           load,
  input  logic [BIN-1:0] din,
  output logic [BWW-1:0] word_nxt,
  output logic           full
);
  import mvu_pkg::*;

  localparam int RATIO = BWW / BIN;
  localparam int IW    = clog2_min1(RATIO);

  logic [BWW-1:0] pack_q, pack_d;
  logic [IW-1:0]  idx_q, idx_d;

  // Set while the next accepted beat completes the word.
  assign full = (idx_q == IW'(RATIO - 1));

  always_comb begin
    word_nxt = pack_q;
    word_nxt[idx_q*BIN +: BIN] = din;
    pack_d = pack_q;
    idx_d  = idx_q;
    if (clr) begin
      pack_d = '0;
      idx_d  = '0;
    end else if (load) begin
      pack_d = word_nxt;
      idx_d  = full ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q <= '0;
      idx_q  <= '0;
    end else begin
      pack_q <= pack_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/mvu_weight_loader.sv
// Packs a narrow host stream into full weight-bank words and writes them into one selected MVU per command.
// One bank word per RATIO+1 cycles at full stream rate; wrw_en follows the last beat accept by one cycle.
module mvu_weight_loader #(
  parameter int NMVU    = mvu_pkg::NMVU,
  parameter int BWBANKA = mvu_pkg::BWBANKA,
  parameter int BWBANKW = mvu_pkg::BWBANKW,
  parameter int BIN     = mvu_pkg::BWLBIN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(NMVU)-1:0]    cmd_mvu,
  input  logic [BWBANKA-1:0]         cmd_addr,
  input  logic [BWBANKA:0]           cmd_count,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BIN-1:0]             s_data,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [NMVU-1:0]            wrw_en,
  output logic [NMVU*BWBANKA-1:0]    wrw_addr,
  output logic [NMVU*BWBANKW-1:0]    wrw_word
);
  import mvu_pkg::*;

  localparam int MW = $clog2(NMVU);
  localparam int CW = BWBANKA + 1;

  wl_state_t          state_q, state_d;
  logic [MW-1:0]      mvu_q, mvu_d;
  logic [BWBANKA-1:0] base_q, base_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      widx_q, widx_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               s_ready_q, s_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [NMVU-1:0]    wrw_en_q, wrw_en_d;
  logic [BWBANKA-1:0] wrw_addr_q, wrw_addr_d;
  logic [BWBANKW-1:0] wrw_word_q, wrw_word_d;

  logic               pk_clr, pk_load, pk_full;
  logic [BWBANKW-1:0] pk_word;
  logic [CW-1:0]      widx_inc;
  logic               mvu_bad;

  assign widx_inc = widx_q + 1'b1;
  assign mvu_bad  = (int'(cmd_mvu) >= NMVU);

  mvu_beat_packer #(
    .BIN (BIN),
    .BWW (BWBANKW)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr),
    .load     (pk_load),
    .din      (s_data),
    .word_nxt (pk_word),
    .full     (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    mvu_d      = mvu_q;
    base_d     = base_q;
    count_d    = count_q;
    widx_d     = widx_q;
    wrw_en_d   = '0;
    wrw_addr_d = wrw_addr_q;
    wrw_word_d = wrw_word_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pk_clr     = 1'b0;
    pk_load    = 1'b0;

    case (state_q)
      WL_IDLE: begin
        if (cmd_valid) begin
          mvu_d   = cmd_mvu;
          base_d  = cmd_addr;
          count_d = cmd_count;
          widx_d  = '0;
          pk_clr  = 1'b1;
          if (mvu_bad) begin
            state_d = WL_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (cmd_count == '0) begin
            state_d = WL_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = WL_FILL;
          end
        end
      end
      WL_FILL: begin
        if (s_valid) begin
          pk_load = 1'b1;
          // The write registers load on the last beat so wrw_en shows in the WRITE cycle.
          if (pk_full) begin
            state_d    = WL_WRITE;
            wrw_en_d   = NMVU'(1) << mvu_q;
            wrw_addr_d = base_q + widx_q[BWBANKA-1:0];
            wrw_word_d = pk_word;
          end
        end
      end
      WL_WRITE: begin
        widx_d = widx_inc;
        if (widx_inc == count_q) begin
          state_d = WL_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = WL_FILL;
        end
      end
      WL_FIN: begin
        state_d = WL_IDLE;
      end
      default: begin
        state_d = WL_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = WL_IDLE;
      pk_clr     = 1'b1;
      pk_load    = 1'b0;
      wrw_en_d   = '0;
      wrw_addr_d = wrw_addr_q;
      wrw_word_d = wrw_word_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end

    cmd_ready_d = (state_d == WL_IDLE);
    s_ready_d   = (state_d == WL_FILL);
    busy_d      = (state_d == WL_FILL) || (state_d == WL_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WL_IDLE;
      mvu_q       <= '0;
      base_q      <= '0;
      count_q     <= '0;
      widx_q      <= '0;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wrw_en_q    <= '0;
      wrw_addr_q  <= '0;
      wrw_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      mvu_q       <= mvu_d;
      base_q      <= base_d;
      count_q     <= count_d;
      widx_q      <= widx_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wrw_en_q    <= wrw_en_d;
      wrw_addr_q  <= wrw_addr_d;
      wrw_word_q  <= wrw_word_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wrw_en    = wrw_en_q;
  assign wrw_addr  = {NMVU{wrw_addr_q}};
  assign wrw_word  = {NMVU{wrw_word_q}};

endmodule

// File: tb/tb_mvu_weight_loader.sv
// Randomized scoreboard bench for mvu_weight_loader, with a second NMVU=6 instance for out-of-range targets.
module tb_mvu_weight_loader;
  localparam int NM    = 8;
  localparam int NM6   = 6;
  localparam int AW    = 9;
  localparam int CW    = AW + 1;
  localparam int WW    = 4096;
  localparam int BW    = 32;
  localparam int RATIO = WW / BW;
  localparam int TMO   = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid  = 1'b0;
  logic          cmd_valid6 = 1'b0;
  logic          s_valid    = 1'b0;
  logic          s_valid6   = 1'b0;
  logic          abort      = 1'b0;
  logic [2:0]    cmd_mvu    = '0;
  logic [AW-1:0] cmd_addr   = '0;
  logic [CW-1:0] cmd_count  = '0;
  logic [BW-1:0] s_data     = '0;

  logic             cmd_ready, s_ready, busy, done, err;
  logic [NM-1:0]    wrw_en;
  logic [NM*AW-1:0] wrw_addr;
  logic [NM*WW-1:0] wrw_word;

  logic              cmd_ready6, s_ready6, busy6, done6, err6;
  logic [NM6-1:0]    wrw_en6;
  logic [NM6*AW-1:0] wrw_addr6;
  logic [NM6*WW-1:0] wrw_word6;

  mvu_weight_loader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mvu(cmd_mvu),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .abort(abort), .busy(busy), .done(done), .err(err),
    .wrw_en(wrw_en), .wrw_addr(wrw_addr), .wrw_word(wrw_word)
  );

  mvu_weight_loader #(.NMVU(NM6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6), .cmd_mvu(cmd_mvu),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data),
    .abort(1'b0), .busy(busy6), .done(done6), .err(err6),
    .wrw_en(wrw_en6), .wrw_addr(wrw_addr6), .wrw_word(wrw_word6)
  );

  typedef struct {
    logic [NM-1:0] en;
    logic [AW-1:0] addr;
    logic [WW-1:0] word;
  } wr_t;

  wr_t           exp_wr[$];
  logic          exp_err[$];
  logic [BW-1:0] beats[$];
  int n_tests = 0;
  int n_fail  = 0;

  int             wr6_cnt   = 0;
  int             done6_cnt = 0;
  logic           err6_last = 1'b0;
  logic [NM6-1:0] en6_last  = '0;
  logic [AW-1:0]  addr6_last = '0;
  logic [WW-1:0]  word6_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    int bad = -1;
    for (int k = 0; k < RATIO; k++)
      if (bad < 0 && act[k*BW +: BW] !== exp[k*BW +: BW]) bad = k;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: beat %0d got 0x%08h expected 0x%08h", name, bad, act[bad*BW +: BW], exp[bad*BW +: BW]);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: write i goes to (addr+i) mod bank depth and carries beats i*RATIO .. i*RATIO+RATIO-1, first beat in LSBs.
  function automatic void model(input int mvu, input int addr, input int nwr, input bit with_done, input bit e_err);
    wr_t w;
    for (int i = 0; i < nwr; i++) begin
      w.en   = NM'(1) << mvu;
      w.addr = AW'((addr + i) % (1 << AW));
      for (int k = 0; k < RATIO; k++) w.word[k*BW +: BW] = beats[i*RATIO + k];
      exp_wr.push_back(w);
    end
    if (with_done) exp_err.push_back(e_err);
  endfunction

  task automatic gen_beats(input int n, input bit rnd);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(rnd ? $urandom : BW'(i % RATIO));
  endtask

  task automatic send_cmd(input bit sel, input int mvu, input int addr, input int count);
    int n = 0;
    @(negedge clk);
    cmd_mvu   = 3'(mvu);
    cmd_addr  = AW'(addr);
    cmd_count = CW'(count);
    if (sel) cmd_valid6 = 1'b1; else cmd_valid = 1'b1;
    while (!(sel ? cmd_ready6 : cmd_ready) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) fail_now("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_valid6 = 1'b0;
  endtask

  task automatic send_beats(input bit sel, input int first, input int n, input bit stall);
    int i = 0;
    int w = 0;
    bit v;
    while (i < n && w < TMO) begin
      @(negedge clk);
      v = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_data = v ? beats[first + i] : $urandom;
      if (sel) s_valid6 = v; else s_valid = v;
      if (v && (sel ? s_ready6 : s_ready)) begin
        i++;
        w = 0;
      end else begin
        w++;
      end
    end
    if (i < n) fail_now("beat_timeout");
    @(negedge clk);
    s_valid  = 1'b0;
    s_valid6 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    @(negedge clk);
    while (!(sel ? cmd_ready6 : cmd_ready) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) fail_now("idle_timeout");
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s_cmd_ready", tag), 64'(cmd_ready), 64'(1));
    check($sformatf("%s_s_ready", tag), 64'(s_ready), 64'(0));
    check($sformatf("%s_busy", tag), 64'(busy), 64'(0));
    check($sformatf("%s_done_err", tag), 64'({done, err}), 64'(0));
    check($sformatf("%s_wrw_en", tag), 64'(wrw_en), 64'(0));
    check($sformatf("%s_wrw_addr_nz", tag), 64'(|wrw_addr), 64'(0));
    check($sformatf("%s_wrw_word_nz", tag), 64'(|wrw_word), 64'(0));
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    int  bad;
    int  idx;
    if (rst_n) begin
      if (wrw_en != '0) begin
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: en=0x%0h addr=0x%0h", wrw_en, wrw_addr[AW-1:0]);
        end else begin
          e   = exp_wr.pop_front();
          bad = 0;
          idx = 0;
          for (int s = 0; s < NM; s++) begin
            if (wrw_addr[s*AW +: AW] !== e.addr) bad++;
            if (e.en[s]) idx = s;
          end
          check("wr_en", 64'(wrw_en), 64'(e.en));
          check("wr_addr", 64'(wrw_addr[idx*AW +: AW]), 64'(e.addr));
          check("wr_addr_slices_bad", 64'(bad), 64'(0));
          check_word("wr_word", wrw_word[idx*WW +: WW], e.word);
        end
      end
      if (done) begin
        if (exp_err.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: err=%0b", err);
        end else begin
          check("done_err", 64'(err), 64'(exp_err.pop_front()));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wrw_en6 != '0) begin
        wr6_cnt++;
        en6_last   = wrw_en6;
        addr6_last = wrw_addr6[5*AW +: AW];
        word6_last = wrw_word6[5*WW +: WW];
      end
      if (done6) begin
        done6_cnt++;
        err6_last = err6;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int m;
    int c;
    int cyc;
    bit seen;
    bit sr_seen;
    logic [WW-1:0] xw;

    #1 rst_n = 1'b0;
    #2;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1: single word, beat k carries k
    gen_beats(RATIO, 1'b0);
    model(2, 5, 1, 1'b1, 1'b0);
    send_cmd(1'b0, 2, 5, 1);
    send_beats(1'b0, 0, RATIO, 1'b0);
    wait_idle(1'b0);

    // T2: address wrap across the top of the bank
    gen_beats(3*RATIO, 1'b1);
    model(0, 510, 3, 1'b1, 1'b0);
    send_cmd(1'b0, 0, 510, 3);
    send_beats(1'b0, 0, 3*RATIO, 1'b0);
    wait_idle(1'b0);

    // T3: random stalls on the stream
    a = $urandom_range(0, 511);
    gen_beats(2*RATIO, 1'b1);
    model(7, a, 2, 1'b1, 1'b0);
    send_cmd(1'b0, 7, a, 2);
    send_beats(1'b0, 0, 2*RATIO, 1'b1);
    wait_idle(1'b0);

    // T4: zero count
    model(1, 33, 0, 1'b1, 1'b0);
    send_cmd(1'b0, 1, 33, 0);
    seen = 1'b0;
    sr_seen = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      sr_seen = sr_seen | s_ready;
      if (done && !seen) begin
        seen = 1'b1;
        cyc = i;
      end
    end
    check("t4_done_within_2", 64'(seen && cyc <= 2), 64'(1));
    check("t4_s_ready_seen", 64'(sr_seen), 64'(0));
    wait_idle(1'b0);

    // T5: out-of-range target on the six-MVU instance, then a legal command
    send_cmd(1'b1, 6, 3, 2);
    for (int i = 0; i < 4 && done6_cnt == 0; i++) @(negedge clk);
    check("t5_bad_done", 64'(done6_cnt), 64'(1));
    check("t5_bad_err", 64'(err6_last), 64'(1));
    check("t5_bad_writes", 64'(wr6_cnt), 64'(0));
    wait_idle(1'b1);
    gen_beats(RATIO, 1'b1);
    send_cmd(1'b1, 5, 7, 1);
    send_beats(1'b1, 0, RATIO, 1'b0);
    wait_idle(1'b1);
    for (int k = 0; k < RATIO; k++) xw[k*BW +: BW] = beats[k];
    check("t5_writes", 64'(wr6_cnt), 64'(1));
    check("t5_en", 64'(en6_last), 64'(6'b100000));
    check("t5_addr", 64'(addr6_last), 64'(7));
    check_word("t5_word", word6_last, xw);
    check("t5_done_cnt", 64'(done6_cnt), 64'(2));
    check("t5_err_clear", 64'(err6_last), 64'(0));

    // T6: abort half-way through word 1 of four
    gen_beats(4*RATIO, 1'b1);
    model(3, 100, 1, 1'b0, 1'b0);
    send_cmd(1'b0, 3, 100, 4);
    send_beats(1'b0, 0, RATIO + 64, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_cmd_ready", 64'(cmd_ready), 64'(1));
    check("t6_busy", 64'(busy), 64'(0));
    repeat (300) @(negedge clk);
    gen_beats(2*RATIO, 1'b0);
    model(1, 20, 2, 1'b1, 1'b0);
    send_cmd(1'b0, 1, 20, 2);
    send_beats(1'b0, 0, 2*RATIO, 1'b0);
    wait_idle(1'b0);

    // T7: abort coinciding with the last beat suppresses the write
    gen_beats(RATIO, 1'b1);
    send_cmd(1'b0, 4, 9, 1);
    send_beats(1'b0, 0, RATIO - 1, 1'b0);
    s_valid = 1'b1;
    s_data  = beats[RATIO-1];
    abort   = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    abort   = 1'b0;
    check("t7_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (5) @(negedge clk);

    // T8: random commands with random stalls
    for (int r = 0; r < 3; r++) begin
      m = $urandom_range(0, NM - 1);
      a = $urandom_range(0, 511);
      c = $urandom_range(1, 2);
      gen_beats(c*RATIO, 1'b1);
      model(m, a, c, 1'b1, 1'b0);
      send_cmd(1'b0, m, a, c);
      send_beats(1'b0, 0, c*RATIO, 1'b1);
      wait_idle(1'b0);
    end

    // Asynchronous reset in the middle of FILL
    gen_beats(2*RATIO, 1'b1);
    send_cmd(1'b0, 6, 44, 2);
    send_beats(1'b0, 0, 50, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset("mid_fill");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check("exp_writes_left", 64'(exp_wr.size()), 64'(0));
    check("exp_dones_left", 64'(exp_err.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
